// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    DROP
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer holding fetched words with their fetch addresses.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_instr,
  input  logic [WIDTH-1:0] push_pc,
  input  logic             pop,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] head_instr,
  output logic [WIDTH-1:0] head_pc
);

  logic [WIDTH-1:0] mem_instr [DEPTH];
  logic [WIDTH-1:0] mem_pc    [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // When full, a push lands on the slot being popped at the same edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= push_instr;
      mem_pc[wr_ptr]    <= push_pc;
    end
  end

  assign head_instr = mem_instr[rd_ptr];
  assign head_pc    = mem_pc[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one outstanding memory request, flush-aware, feeding a 2-entry buffer.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_advance,
  input  logic             flush,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_t     state;
  logic [WIDTH-1:0] pending_pc;
  logic [WIDTH-1:0] aligned_addr;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] head_instr;
  logic [WIDTH-1:0] head_pc;
  logic             buf_full;
  logic             req_valid;
  logic             handshake;
  logic             push;
  logic             pop;
  logic             have_instr;

  assign aligned_addr = pc & ~WIDTH'(3);
  assign buf_full     = (count == CW'(DEPTH));

  // Requests are only issued when a buffer slot is guaranteed for the response.
  assign req_valid  = !rst && (state == REQ) && !buf_full && !flush;
  assign handshake  = req_valid && imem_req_ready;
  assign push       = !rst && (state == WAIT) && imem_rsp_valid && !flush;
  assign have_instr = !rst && (count != '0);
  assign pop        = have_instr && instr_ready && !flush;

  assign imem_req_valid = req_valid;
  assign pc_advance     = handshake;
  assign imem_addr      = rst ? '0 : aligned_addr;
  assign instr_valid    = have_instr;
  assign instr          = rst ? '0 : head_instr;
  assign instr_pc       = rst ? '0 : head_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= REQ;
      pending_pc <= '0;
    end else begin
      case (state)
        REQ: begin
          if (handshake) begin
            state      <= WAIT;
            pending_pc <= aligned_addr;
          end
        end
        WAIT: begin
          if (imem_rsp_valid)  state <= REQ;
          else if (flush)      state <= DROP;
        end
        DROP: begin
          if (imem_rsp_valid)  state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clear      (flush),
    .push       (push),
    .push_instr (imem_rsp_data),
    .push_pc    (pending_pc),
    .pop        (pop),
    .count      (count),
    .head_instr (head_instr),
    .head_pc    (head_pc)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch with a latency-programmable memory and a PC register model.
module tb_instr_fetch;
  import fetch_pkg::*;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_advance;
  logic        flush;
  logic [31:0] flush_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          grants = 0;
  int          grant_limit = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic        req_ready_en;
  logic [31:0] mem_addr = '0;
  exp_t        exp_q[$];
  int          pop_cycles[$];

  instr_fetch #(.WIDTH(32), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_advance     (pc_advance),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // PC register: redirect on flush, otherwise step by 4 when the fetch unit allows.
  always @(posedge clk) begin
    if (rst)             pc <= '0;
    else if (flush)      pc <= flush_target;
    else if (pc_advance) pc <= pc + 32'd4;
  end

  // Memory answers mem_lat cycles after the accepted request; data tags the address.
  assign imem_req_ready = req_ready_en && (grants < grant_limit);
  assign imem_rsp_valid = (mem_cnt == 1);
  assign imem_rsp_data  = {16'hC0DE, mem_addr[15:0]};

  always @(posedge clk) begin
    if (rst) begin
      mem_cnt <= 0;
    end else if (imem_req_valid && imem_req_ready) begin
      mem_cnt  <= mem_lat;
      mem_addr <= imem_addr;
      grants   <= grants + 1;
    end else if (mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  // Monitor: every accepted decode beat is compared with the oldest expectation.
  always @(negedge clk) begin
    if (instr_valid && instr_ready && !flush) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("[TB] FAIL unexpected_pop got instr=%h pc=%h, required no output", instr, instr_pc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (instr !== e.instr || instr_pc !== e.pc) begin
          errors = errors + 1;
          $display("[TB] FAIL decode_beat got instr=%h pc=%h, required instr=%h pc=%h",
                   instr, instr_pc, e.instr, e.pc);
        end
      end
      pop_cycles.push_back(cycle);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rdy, input int lat, input int extra_grants);
    @(posedge clk) #1;
    instr_ready = rdy;
    mem_lat     = lat;
    grant_limit = grant_limit + extra_grants;
  endtask

  task automatic pulseFlush(input logic [31:0] target);
    @(posedge clk) #1;
    flush        = 1'b1;
    flush_target = target;
    @(posedge clk) #1;
    flush = 1'b0;
  endtask

  task automatic expectBeat(input logic [31:0] data, input logic [31:0] addr);
    exp_t e;
    e.instr = data;
    e.pc    = addr;
    exp_q.push_back(e);
  endtask

  task automatic waitGrants(input int target, input int budget);
    int n = 0;
    while (grants < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (grants < target) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL grant_timeout got %0d grants, required %0d", grants, target);
    end
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL drain_timeout got %0d pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    rst          = 1'b1;
    flush        = 1'b0;
    flush_target = '0;
    instr_ready  = 1'b0;
    req_ready_en = 1'b1;

    // Reset: every output low.
    repeat (2) @(negedge clk);
    checkOutput("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("rst_pc_advance", {31'd0, pc_advance}, 32'd0);
    checkOutput("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'd0);
    checkOutput("rst_instr", instr, 32'd0);
    checkOutput("rst_instr_pc", instr_pc, 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;

    // Streaming with single-cycle memory: 0x0, 0x4, 0x8 one every two cycles.
    $display("[TB] streaming fetch");
    pop_cycles.delete();
    expectBeat(32'hC0DE0000, 32'h0);
    expectBeat(32'hC0DE0004, 32'h4);
    expectBeat(32'hC0DE0008, 32'h8);
    applyStimulus(1'b1, 1, 3);
    waitDrain(40);
    checkOutput("pop_count", pop_cycles.size(), 32'd3);
    if (pop_cycles.size() >= 3) begin
      checkOutput("cadence_1", pop_cycles[1] - pop_cycles[0], 32'd2);
      checkOutput("cadence_2", pop_cycles[2] - pop_cycles[1], 32'd2);
    end

    // Backpressure: buffer fills to two entries and requests stop.
    $display("[TB] decode backpressure");
    expectBeat(32'hC0DE000C, 32'hC);
    expectBeat(32'hC0DE0010, 32'h10);
    expectBeat(32'hC0DE0014, 32'h14);
    applyStimulus(1'b0, 1, 3);
    repeat (10) @(negedge clk);
    checkOutput("full_instr_valid", {31'd0, instr_valid}, 32'd1);
    checkOutput("full_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("full_pc_advance", {31'd0, pc_advance}, 32'd0);
    checkOutput("full_head_pc", instr_pc, 32'hC);
    checkOutput("full_head_instr", instr, 32'hC0DE000C);
    checkOutput("full_grants", grants, 32'd5);
    applyStimulus(1'b1, 1, 0);
    waitDrain(40);

    // Flush while waiting on a slow response: late data dropped, refetch at 0x100.
    $display("[TB] flush during wait");
    expectBeat(32'hC0DE0100, 32'h100);
    applyStimulus(1'b1, 3, 2);
    waitGrants(7, 20);
    pulseFlush(32'h100);
    @(negedge clk);
    checkOutput("drop_state", 32'(dut.state), 32'(DROP));
    checkOutput("drop_rsp_seen", {31'd0, imem_rsp_valid}, 32'd1);
    checkOutput("drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    waitDrain(40);

    // Flush coinciding with a response while the buffer holds an entry.
    $display("[TB] flush with response");
    applyStimulus(1'b0, 2, 2);
    waitGrants(10, 30);
    @(posedge clk) #1;
    flush        = 1'b1;
    flush_target = 32'h200;
    @(negedge clk);
    checkOutput("fr_rsp_valid", {31'd0, imem_rsp_valid}, 32'd1);
    checkOutput("fr_buffered", {31'd0, instr_valid}, 32'd1);
    checkOutput("fr_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("fr_pc_advance", {31'd0, pc_advance}, 32'd0);
    @(posedge clk) #1;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("fr_empty", {31'd0, instr_valid}, 32'd0);
    checkOutput("fr_state", 32'(dut.state), 32'(REQ));
    checkOutput("fr_next_addr", imem_addr, 32'h200);

    // Memory not ready: request held with a stable address.
    $display("[TB] request stall");
    applyStimulus(1'b1, 1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      checkOutput("stall_addr", imem_addr, 32'h200);
      checkOutput("stall_pc_advance", {31'd0, pc_advance}, 32'd0);
    end
    expectBeat(32'hC0DE0200, 32'h200);
    applyStimulus(1'b1, 1, 1);
    waitDrain(40);

    // Misaligned PC fetches the containing word.
    $display("[TB] misaligned pc");
    pulseFlush(32'h6);
    @(negedge clk);
    checkOutput("align_addr", imem_addr, 32'h4);
    expectBeat(32'hC0DE0004, 32'h4);
    applyStimulus(1'b1, 1, 1);
    waitDrain(40);

    // Reset in the middle of an outstanding request with a buffered entry.
    $display("[TB] reset during wait");
    applyStimulus(1'b0, 1, 1);
    waitGrants(13, 20);
    mem_lat     = 3;
    grant_limit = grant_limit + 1;
    waitGrants(14, 20);
    @(posedge clk) #1;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mrst_instr_valid", {31'd0, instr_valid}, 32'd0);
    checkOutput("mrst_addr", imem_addr, 32'd0);
    checkOutput("mrst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    checkOutput("mrst_instr", instr, 32'd0);
    checkOutput("mrst_instr_pc", instr_pc, 32'd0);
    @(posedge clk) #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_empty", {31'd0, instr_valid}, 32'd0);
    checkOutput("post_rst_state", 32'(dut.state), 32'(REQ));
    checkOutput("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);

    checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout got no finish, required finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
